// File: rtl/spi_rx_pkg.sv
// Shared definitions for the three-slot return-to-zero SPI link: FSM states and slot levels.
// Reusable by the transmitter, the receiver and benches.
package spi_rx_pkg;
   typedef enum logic [1:0] {
      HUNT = 2'd0,
      DATA = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam int   SLOTS_PER_BIT = 3;
   localparam logic MARKER_LVL    = 1'b1;
   localparam logic GAP_LVL       = 1'b0;

   // Number of line slots occupied by one contiguous word.
   function automatic int word_slots(input int data_w);
      return SLOTS_PER_BIT * data_w;
   endfunction
endpackage

// File: rtl/spi_rx_sync.sv
// Parameterized-width two-flop synchronizer with a per-bit reset value.
// Used by spi_rx_deframer only when SPI_RX_SYNC_EN is defined.
module spi_rx_sync #(
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_sync
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
         if (rst) begin
            r_meta[gi] <= RST_VAL[gi];
            r_sync[gi] <= RST_VAL[gi];
         end else begin
            r_meta[gi] <= i_async[gi];
            r_sync[gi] <= r_meta[gi];
         end
      end
   end

   assign o_sync = r_sync;
endmodule

// File: rtl/spi_rx_deframer.sv
// Three-slot RZ SPI receiver: recovers marker/data/gap bits into LSB-first words behind a
// one-deep valid/ready buffer. Define SPI_RX_SYNC_EN to add two-flop input synchronizers.
module spi_rx_deframer
   import spi_rx_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              en_n,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              busy,
   output logic              frame_err,
   output logic              abort,
   output logic              overrun
);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic w_din;
   logic w_en_n;

`ifdef SPI_RX_SYNC_EN
   logic [1:0] w_sync;

   // Idle line after reset: en_n high, din low.
   spi_rx_sync #(
      .WIDTH   (2),
      .RST_VAL (2'b10)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .i_async ({en_n, din}),
      .o_sync  (w_sync)
   );

   assign w_din  = w_sync[0];
   assign w_en_n = w_sync[1];
`else
   assign w_din  = din;
   assign w_en_n = en_n;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic              w_done;
   logic              w_ferr_nxt;
   logic              w_abort_nxt;

   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] w_data_nxt;
   logic              r_valid;
   logic              w_valid_nxt;
   logic              w_ovr_nxt;
   logic              r_busy;
   logic              r_ferr;
   logic              r_abort;
   logic              r_ovr;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= HUNT;
         r_cnt   <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_shift <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_shift_nxt = r_shift;
      w_done      = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_abort_nxt = 1'b0;
      // Enable dropping mid-word wins over anything the slot itself would do.
      if (w_en_n && ((r_state != HUNT) || (r_cnt != '0))) begin
         w_abort_nxt = 1'b1;
         w_state_nxt = HUNT;
         w_cnt_nxt   = '0;
         w_shift_nxt = '0;
      end else begin
         case (r_state)
            HUNT: begin
               if (!w_en_n && (w_din == MARKER_LVL)) begin
                  w_state_nxt = DATA;
               end
            end
            DATA: begin
               for (int i = 0; i < DATA_W; i++) begin
                  if (r_cnt == CNT_W'(i)) begin
                     w_shift_nxt[i] = w_din;
                  end
               end
               w_cnt_nxt   = r_cnt + CNT_W'(1);
               w_state_nxt = GAP;
            end
            GAP: begin
               w_state_nxt = HUNT;
               if (w_din == GAP_LVL) begin
                  if (r_cnt == CNT_W'(DATA_W)) begin
                     w_done      = 1'b1;
                     w_cnt_nxt   = '0;
                     w_shift_nxt = '0;
                  end
               end else begin
                  w_ferr_nxt  = 1'b1;
                  w_cnt_nxt   = '0;
                  w_shift_nxt = '0;
               end
            end
            default: begin
               w_state_nxt = HUNT;
            end
         endcase
      end
   end

   // r_shift still holds the full word on the completing cycle; it is cleared on the same edge.
   always_comb begin
      w_data_nxt  = r_data;
      w_valid_nxt = r_valid;
      w_ovr_nxt   = 1'b0;
      if (w_done) begin
         if (!r_valid || rx_ready) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
         end else begin
            w_ovr_nxt = 1'b1;
         end
      end else if (rx_ready) begin
         w_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_data  <= '0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_ferr  <= 1'b0;
         r_abort <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_data  <= w_data_nxt;
         r_valid <= w_valid_nxt;
         r_busy  <= (w_state_nxt != HUNT) || (w_cnt_nxt != '0);
         r_ferr  <= w_ferr_nxt;
         r_abort <= w_abort_nxt;
         r_ovr   <= w_ovr_nxt;
      end
   end

   assign rx_data   = r_data;
   assign rx_valid  = r_valid;
   assign busy      = r_busy;
   assign frame_err = r_ferr;
   assign abort     = r_abort;
   assign overrun   = r_ovr;
endmodule

// File: tb/tb_spi_rx_deframer.sv
// Directed bench for spi_rx_deframer: one slot per clock, outputs observed 1 time unit after
// each edge; pulse/rise counters are kept per scenario and checked with immediate assertions.
module tb_spi_rx_deframer;
   import spi_rx_pkg::*;

   localparam int DATA_W = 8;
`ifdef SPI_RX_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              din = 1'b0;
   logic              en_n = 1'b1;
   logic              rx_ready = 1'b0;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              frame_err;
   logic              abort;
   logic              overrun;

   int checks = 0;
   int failures = 0;
   int t = 0;
   int n_ferr, n_abort, n_ovr, n_rise, rise_t, m;
   logic              prev_valid = 1'b0;
   logic [DATA_W-1:0] cap_data;
   logic [DATA_W-1:0] word;

   spi_rx_deframer #(.DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .en_n      (en_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .busy      (busy),
      .frame_err (frame_err),
      .abort     (abort),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      n_ferr = 0; n_abort = 0; n_ovr = 0; n_rise = 0; rise_t = -1; cap_data = '0;
   endtask

   // Drive one line slot, let the DUT sample it, then tally what the outputs show.
   task automatic slot(input logic d, input logic e);
      din  = d;
      en_n = e;
      @(posedge clk);
      t++;
      #1;
      if (frame_err) n_ferr++;
      if (abort) n_abort++;
      if (overrun) n_ovr++;
      if (rx_valid && !prev_valid) begin
         n_rise++;
         rise_t   = t;
         cap_data = rx_data;
      end
      prev_valid = rx_valid;
   endtask

   task automatic send_bit(input logic b, input logic gap);
      slot(1'b1, 1'b0);
      slot(b, 1'b0);
      slot(gap, 1'b0);
   endtask

   task automatic send_word(input logic [DATA_W-1:0] w);
      for (int i = 0; i < DATA_W; i++) send_bit(w[i], 1'b0);
   endtask

   task automatic idle(input int n, input logic e);
      for (int i = 0; i < n; i++) slot(1'b0, e);
   endtask

   initial begin
      clear_counts();
      // Reset state
      rst = 1'b1;
      idle(3, 1'b1);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_abort", abort, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      idle(3, 1'b1);

      // 0xA5 contiguous, rx_ready held high: one-cycle valid pulse at the documented latency
      clear_counts();
      rx_ready = 1'b1;
      m = t + 1;
      send_word(8'hA5);
      idle(4, 1'b0);
      check("a5_rise_count", n_rise, 1);
      check("a5_rise_edge", rise_t - m, word_slots(DATA_W) - 1 + LAT);
      check("a5_data", cap_data, 8'hA5);
      check("a5_valid_consumed", rx_valid, 0);
      check("a5_ferr", n_ferr, 0);
      check("a5_abort", n_abort, 0);
      check("a5_ovr", n_ovr, 0);
      check("a5_busy_idle", busy, 0);

      // 0x3C then 0xC3 back-to-back with no consumer: second word dropped
      clear_counts();
      rx_ready = 1'b0;
      send_word(8'h3C);
      send_word(8'hC3);
      idle(4, 1'b0);
      check("ovr_count", n_ovr, 1);
      check("ovr_held_data", rx_data, 8'h3C);
      check("ovr_held_valid", rx_valid, 1);
      rx_ready = 1'b1;
      slot(1'b0, 1'b0);
      rx_ready = 1'b0;
      check("ovr_after_ready_valid", rx_valid, 0);
      check("ovr_after_ready_data", rx_data, 8'h3C);

      // Same pair, consumer accepts exactly on the second word's completion edge
      clear_counts();
      send_word(8'h3C);
      word = 8'hC3;
      for (int i = 0; i < DATA_W - 1; i++) send_bit(word[i], 1'b0);
      slot(1'b1, 1'b0);
      slot(word[DATA_W-1], 1'b0);
      for (int k = 0; k <= LAT; k++) begin
         rx_ready = (k == LAT);
         slot(1'b0, 1'b0);
      end
      rx_ready = 1'b0;
      idle(3, 1'b0);
      check("same_cycle_data", rx_data, 8'hC3);
      check("same_cycle_valid", rx_valid, 1);
      check("same_cycle_rises", n_rise, 1);
      check("same_cycle_ovr", n_ovr, 0);
      rx_ready = 1'b1;
      slot(1'b0, 1'b0);

      // Bad gap on bit 3, then a clean 0x01
      clear_counts();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b1);
      idle(2, 1'b0);
      send_word(8'h01);
      idle(4, 1'b0);
      check("ferr_count", n_ferr, 1);
      check("ferr_rises", n_rise, 1);
      check("ferr_next_word", cap_data, 8'h01);
      check("ferr_abort", n_abort, 0);

      // 0x96 with 0..5 idle zero slots between bits
      clear_counts();
      word = 8'h96;
      for (int i = 0; i < DATA_W; i++) begin
         send_bit(word[i], 1'b0);
         idle(int'($urandom_range(0, 5)), 1'b0);
      end
      idle(4, 1'b0);
      check("idle_gaps_data", cap_data, 8'h96);
      check("idle_gaps_rises", n_rise, 1);
      check("idle_gaps_errors", n_ferr + n_abort + n_ovr, 0);

      // en_n raised after bit 5
      clear_counts();
      word = 8'h5A;
      for (int i = 0; i < 6; i++) send_bit(word[i], 1'b0);
      check("abort_busy_before", busy, 1);
      idle(4, 1'b1);
      check("abort_count", n_abort, 1);
      check("abort_busy_after", busy, 0);
      check("abort_no_word", n_rise, 0);
      check("abort_ferr", n_ferr, 0);

      // Reset mid-word: everything back to reset values, no abort
      clear_counts();
      for (int i = 0; i < 4; i++) send_bit(word[i], 1'b0);
      rst = 1'b1;
      idle(2, 1'b0);
      check("midrst_data", rx_data, 0);
      check("midrst_valid", rx_valid, 0);
      check("midrst_busy", busy, 0);
      rst = 1'b0;
      idle(4, 1'b1);
      check("midrst_no_pulses", n_abort + n_ferr + n_ovr, 0);
      check("midrst_busy_after", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/spi_rx_deframer.md
# spi_rx_deframer

Serial receiver for the team's three-slot return-to-zero SPI link: the counterpart to the byte transmitter that feeds the hash tables' output side. It samples the data and active-low enable lines, recovers each bit from its marker/data/gap triplet, and assembles LSB-first words. Completed words go to the input side of the hash tables through a one-deep valid/ready buffer. It reports framing errors, aborts and overruns.

## Interface
- DATA_W, default 8: bits per word; counter width is $clog2(DATA_W+1).
- clk  in  1  system clock; line slots are one clk cycle each.
- rst  in  1  reset, synchronous, active-high.
- din  in  1  serial data line.
- en_n  in  1  frame enable, active-low; high means the line is idle.
- rx_data  out  DATA_W  received word, LSB = first bit on the line.
- rx_valid  out  1  rx_data holds an unconsumed word.
- rx_ready  in  1  consumer accepts rx_data this cycle.
- busy  out  1  a word is partially received.
- frame_err  out  1  one-cycle pulse on a bad gap slot.
- abort  out  1  one-cycle pulse when en_n rises mid-word.
- overrun  out  1  one-cycle pulse when a completed word is dropped.

## Operation
- Line format per bit: marker slot = 1, data slot = bit value, gap slot = 0. DATA_W bits per word, LSB first, all with en_n = 0.
- FSM states: HUNT, DATA, GAP.
  - HUNT: if en_n = 0 and din = 1, go to DATA. Zero slots are tolerated indefinitely.
  - DATA: shift din into bit position bit_cnt, increment bit_cnt, go to GAP.
  - GAP, din = 0: if bit_cnt = DATA_W, complete the word, clear bit_cnt, and go to HUNT. Otherwise go to HUNT.
  - GAP, din = 1: pulse frame_err, discard the partial word, clear bit_cnt, and go to HUNT. This slot is not reinterpreted as a marker.
- en_n = 1 in any state other than HUNT, or in HUNT with bit_cnt ≠ 0:
  - pulse abort, clear bit_cnt and the shift register, and go to HUNT.
  - en_n = 1 in HUNT with bit_cnt = 0 is silent.
- busy = (state ≠ HUNT) or (bit_cnt ≠ 0).
- Output buffer:
  - On completion with rx_valid = 0, or with rx_valid = 1 and rx_ready = 1 in the same cycle: load rx_data and set rx_valid.
  - On completion with rx_valid = 1 and rx_ready = 0: drop the new word, keep the held word, and pulse overrun.
  - rx_ready with no completion clears rx_valid.
  - rx_ready while rx_valid = 0 is ignored.
- Reset values:
  - FSM in HUNT; bit_cnt = 0; shift register = 0.
  - rx_data = 0, rx_valid = 0, busy = 0, frame_err = 0, abort = 0, overrun = 0.
  - Reset mid-word discards everything with no abort pulse.

## Timing
- All outputs are registered.
- Latency: rx_valid rises on the cycle after the last gap slot is sampled. For a contiguous word with the first marker sampled at cycle 0, the last gap is at cycle 3·DATA_W−1 and rx_valid is at cycle 3·DATA_W (24 for DATA_W = 8).
- frame_err, abort and overrun assert the cycle after the causing sample, for exactly one cycle.
- Back-to-back words are accepted with no idle slot: a marker may immediately follow the final gap.
- Sustained throughput needs only one rx_ready per 3·DATA_W cycles.

## Configuration
- SPI_RX_SYNC_EN defined:
  - din and en_n each pass through a two-flop synchronizer before the FSM, so asynchronous line sources are safe.
  - All latencies grow by 2 cycles (rx_valid at cycle 3·DATA_W+2).
  - Synchronizer flops reset to din = 0 and en_n = 1.
- Undefined: din and en_n are sampled directly and must be synchronous to clk.

## Structure
- Shared package spi_rx_pkg:
  - state enum (HUNT, DATA, GAP);
  - SLOTS_PER_BIT = 3;
  - MARKER_LVL = 1 and GAP_LVL = 0.
- The package is reusable by the transmitter and by benches.
- One sub-module: spi_rx_sync, a parameterized-width two-flop synchronizer. It is instantiated only under SPI_RX_SYNC_EN.

## Test plan
- Word 0xA5 sent as 24 contiguous slots, rx_ready held at 1: rx_data = 0xA5 and rx_valid pulses at cycle 24 (26 with SYNC); no error pulses.
- Words 0x3C and 0xC3 back-to-back, rx_ready = 0 until after the second: rx_data = 0x3C stays held, overrun pulses once, rx_data = 0x3C after the first rx_ready.
- Same two words with rx_ready asserted in the cycle the second completes: rx_data = 0xC3, rx_valid stays high, no overrun.
- Gap slot of bit 3 driven to 1: frame_err pulses once, no rx_valid; the following valid word 0x01 is received correctly.
- en_n raised after bit 5: abort pulses and busy drops. A rst asserted mid-word instead: all outputs return to reset values with no pulses.
- Idle zero slots (0–5 random) inserted between bits of 0x96: rx_data = 0x96 with no errors.
